// File: rtl/ff_arb_pkg.sv
// Shared types and helpers for the shared-register write arbiter.
package ff_arb_pkg;

  // Arbiter FSM: plain round-robin, or holding the grant for a locked owner.
  typedef enum logic {
    ARB_RR   = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_t;

  // Index width for n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick_onehot.sv
// Rotate-priority picker: the first set request at or after ptr (wrapping)
// wins. Produces a one-hot grant, the winner index, and an any-request flag.
module rr_pick_onehot
  import ff_arb_pkg::*;
#(
  parameter  int N  = 6,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any_valid
);

  // Scan from ptr upward modulo N, keeping only the first set request.
  always_comb begin
    int pos;
    pos       = 0;
    gnt       = '0;
    idx       = '0;
    any_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      if (!any_valid && req[pos]) begin
        any_valid = 1'b1;
        gnt[pos]  = 1'b1;
        idx       = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/ff_wr_arbiter.sv
// Write-path arbiter for a multi-writer state register.
// Handshake: requester i transfers in any cycle where req_i[i] and gnt_o[i]
// are both high; gnt_o is combinational from req_i and at most one-hot.
// A requester holding lock_i keeps the grant for up to MAX_BURST cycles in a
// row; otherwise grants rotate round-robin. The winner's data is registered
// one cycle later onto wr_en_o/wr_data_o/wr_src_o. state_o exposes the FSM.
module ff_wr_arbiter
  import ff_arb_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_REQ    = 6,
  parameter  int MAX_BURST  = 4,
  localparam int IW         = idx_w(NUM_REQ),
  localparam int CW         = idx_w(MAX_BURST + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ-1:0]            lock_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
  input  logic                          stall_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic                          wr_en_o,
  output logic [DATA_WIDTH-1:0]         wr_data_o,
  output logic [IW-1:0]                 wr_src_o,
  output arb_state_t                    state_o
);

  arb_state_t          state;
  logic [IW-1:0]       ptr;
  logic [IW-1:0]       owner;
  logic [CW-1:0]       burst_cnt;

  logic [NUM_REQ-1:0]  pick_gnt;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;

  logic                hold_go;
  logic                hold_grant;
  logic [IW-1:0]       win;
  logic [IW-1:0]       ptr_next;

  rr_pick_onehot #(
    .N (NUM_REQ)
  ) u_pick (
    .req       (req_i),
    .ptr       (ptr),
    .gnt       (pick_gnt),
    .idx       (pick_idx),
    .any_valid (pick_any)
  );

  assign state_o = state;

  // Locked owner keeps the grant while it still requests, still locks and
  // has burst budget left.
  assign hold_go = (state == ARB_HOLD) && req_i[owner] && lock_i[owner] &&
                   (int'(burst_cnt) < MAX_BURST);

  // After an RR grant the pointer moves just past the winner.
  assign ptr_next = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;

  // Grant selection: nothing during reset or stall, else hold owner, else RR.
  always_comb begin
    gnt_o      = '0;
    win        = '0;
    hold_grant = 1'b0;
    if (!rst && !stall_i) begin
      if (hold_go) begin
        gnt_o[owner] = 1'b1;
        win          = owner;
        hold_grant   = 1'b1;
      end else if (pick_any) begin
        gnt_o = pick_gnt;
        win   = pick_idx;
      end
    end
  end

  // FSM, arbitration registers and the registered write stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_RR;
      ptr       <= '0;
      owner     <= '0;
      burst_cnt <= '0;
      wr_en_o   <= 1'b0;
      wr_data_o <= '0;
      wr_src_o  <= '0;
    end else begin
      wr_en_o <= |gnt_o;
      if (|gnt_o) begin
        wr_data_o <= data_i[int'(win)*DATA_WIDTH +: DATA_WIDTH];
        wr_src_o  <= win;
      end
      // A stalled cycle freezes all arbitration state.
      if (!stall_i) begin
        if (hold_grant) begin
          burst_cnt <= burst_cnt + 1'b1;
        end else if (pick_any) begin
          ptr <= ptr_next;
          if (lock_i[win] && (MAX_BURST > 1)) begin
            state     <= ARB_HOLD;
            owner     <= win;
            burst_cnt <= CW'(1);
          end else begin
            state     <= ARB_RR;
            burst_cnt <= '0;
          end
        end else begin
          state     <= ARB_RR;
          burst_cnt <= '0;
        end
      end
    end
  end

endmodule
